// File: rtl/nbody_step_sequencer_if.sv
// Avalon-MM register slave bundle used by the n-body step sequencer.
interface nbody_step_sequencer_if #(
   parameter int REG_AW = 3
);
   logic              chipselect;
   logic              write;
   logic              read;
   logic [REG_AW-1:0] address;
   logic [31:0]       writedata;
   logic [31:0]       readdata;

   modport master (output chipselect, write, read, address, writedata, input readdata);
   modport slave  (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/nbody_step_sequencer.sv
// N-body accelerator control core: Avalon-MM register front-end plus step sequencer.
// Optional NBODY_IRQ_EN adds an irq output that rises with done.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for GO
// ACCEL     | issuing all (i,j) pairs with i!=j, one per cycle
// ACC_DRAIN | waiting ACC_LAT cycles for the last velocity write-back
// POS       | issuing position updates for bodies 0..N-1
// POS_DRAIN | waiting POS_LAT cycles, then step complete
// DONE      | run finished, single cycle before IDLE
module nbody_step_sequencer #(
   parameter int  BODIES  = 512,
   parameter int  STEP_W  = 16,
   parameter int  ACC_LAT = 58,
   parameter int  POS_LAT = 20,
   parameter int  REG_AW  = 3,
   localparam int IW      = $clog2(BODIES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   nbody_step_sequencer_if.slave bus,
   output logic                  pair_valid,
   output logic [IW-1:0]         pair_i,
   output logic [IW-1:0]         pair_j,
   output logic                  first_j,
   output logic                  last_j,
   output logic                  pos_valid,
   output logic [IW-1:0]         pos_idx,
   output logic                  busy
`ifdef NBODY_IRQ_EN
   ,output logic                 irq
`endif
);

   localparam int NW      = IW + 1;
   localparam int LAT_MAX = (ACC_LAT > POS_LAT) ? ACC_LAT : POS_LAT;
   localparam int CW      = $clog2(LAT_MAX) + 1;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_ACCEL     = 3'd1;
   localparam logic [2:0] S_ACC_DRAIN = 3'd2;
   localparam logic [2:0] S_POS       = 3'd3;
   localparam logic [2:0] S_POS_DRAIN = 3'd4;
   localparam logic [2:0] S_DONE      = 3'd5;

   localparam logic [NW-1:0] BODIES_N = NW'(BODIES);
   localparam logic [CW-1:0] ACC_LOAD = CW'(ACC_LAT - 1);
   localparam logic [CW-1:0] POS_LOAD = CW'(POS_LAT - 1);

   logic [2:0]        state_q, state_d;
   logic [NW-1:0]     n_bodies_q, n_bodies_d;
   logic [STEP_W-1:0] steps_q, steps_d;
   logic [STEP_W-1:0] step_count_q, step_count_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [IW-1:0]     i_q, i_d;
   logic [IW-1:0]     j_q, j_d;
   logic [IW-1:0]     pos_q, pos_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [31:0]       readdata_q, readdata_d;

   logic              wr, rd, wr_ctrl, rd_ctrl, go, abort;
   logic [NW-1:0]     i_ext, i_next, j_plus1, j_next, n_last;
   logic              row_end;
   logic [STEP_W-1:0] steps_eff, step_count_inc;

   assign wr      = bus.chipselect & bus.write;
   assign rd      = bus.chipselect & bus.read;
   assign wr_ctrl = wr && (bus.address == REG_AW'(0));
   assign rd_ctrl = rd && (bus.address == REG_AW'(0));
   assign abort   = wr_ctrl && bus.writedata[1];
   assign go      = wr_ctrl && bus.writedata[0];

   // j advance skips the diagonal; running past N-1 ends the row for this i
   assign i_ext   = {1'b0, i_q};
   assign i_next  = i_ext + NW'(1);
   assign j_plus1 = {1'b0, j_q} + NW'(1);
   assign j_next  = (j_plus1 == i_ext) ? j_plus1 + NW'(1) : j_plus1;
   assign row_end = (j_next >= n_bodies_q);
   assign n_last  = n_bodies_q - NW'(1);

   assign steps_eff      = (steps_q == '0) ? STEP_W'(1) : steps_q;
   assign step_count_inc = step_count_q + STEP_W'(1);

   assign busy       = (state_q != S_IDLE);
   assign pair_valid = (state_q == S_ACCEL);
   assign pair_i     = i_q;
   assign pair_j     = j_q;
   assign first_j    = pair_valid && (j_q == ((i_q == '0) ? IW'(1) : IW'(0)));
   assign last_j     = pair_valid && row_end;
   assign pos_valid  = (state_q == S_POS);
   assign pos_idx    = pos_q;
   assign bus.readdata = readdata_q;

   always_comb begin
      state_d      = state_q;
      n_bodies_d   = n_bodies_q;
      steps_d      = steps_q;
      step_count_d = step_count_q;
      done_d       = done_q;
      err_d        = err_q;
      i_d          = i_q;
      j_d          = j_q;
      pos_d        = pos_q;
      cnt_d        = cnt_q;
      readdata_d   = readdata_q;

      if (rd) begin
         case (bus.address)
            REG_AW'(0): readdata_d = {29'b0, err_q, done_q, busy};
            REG_AW'(1): readdata_d = 32'(n_bodies_q);
            REG_AW'(2): readdata_d = 32'(steps_q);
            REG_AW'(3): readdata_d = 32'(step_count_q);
            default:    readdata_d = '0;
         endcase
      end

      if (!busy && wr && (bus.address == REG_AW'(1)))
         n_bodies_d = (bus.writedata > 32'(BODIES)) ? BODIES_N : bus.writedata[NW-1:0];
      if (!busy && wr && (bus.address == REG_AW'(2)))
         steps_d = bus.writedata[STEP_W-1:0];

      case (state_q)
         S_IDLE: begin
            if (go && !abort) begin
               if (n_bodies_q < NW'(2)) begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  err_d        = 1'b0;
                  done_d       = 1'b0;
                  step_count_d = '0;
                  i_d          = '0;
                  j_d          = IW'(1);
                  state_d      = S_ACCEL;
               end
            end
         end
         S_ACCEL: begin
            if (row_end) begin
               if (i_next == n_bodies_q) begin
                  cnt_d   = ACC_LOAD;
                  state_d = S_ACC_DRAIN;
               end else begin
                  i_d = i_next[IW-1:0];
                  j_d = '0;
               end
            end else begin
               j_d = j_next[IW-1:0];
            end
         end
         S_ACC_DRAIN: begin
            if (cnt_q == '0) begin
               pos_d   = '0;
               state_d = S_POS;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_POS: begin
            if ({1'b0, pos_q} == n_last) begin
               cnt_d   = POS_LOAD;
               state_d = S_POS_DRAIN;
            end else begin
               pos_d = pos_q + IW'(1);
            end
         end
         S_POS_DRAIN: begin
            if (cnt_q == '0) begin
               step_count_d = step_count_inc;
               if (step_count_inc == steps_eff) begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  i_d     = '0;
                  j_d     = IW'(1);
                  state_d = S_ACCEL;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // abort discards whatever the current state would have completed this cycle
      if (abort) begin
         state_d      = S_IDLE;
         done_d       = done_q;
         err_d        = err_q;
         step_count_d = step_count_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         n_bodies_q   <= '0;
         steps_q      <= '0;
         step_count_q <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         i_q          <= '0;
         j_q          <= '0;
         pos_q        <= '0;
         cnt_q        <= '0;
         readdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         n_bodies_q   <= n_bodies_d;
         steps_q      <= steps_d;
         step_count_q <= step_count_d;
         done_q       <= done_d;
         err_q        <= err_d;
         i_q          <= i_d;
         j_q          <= j_d;
         pos_q        <= pos_d;
         cnt_q        <= cnt_d;
         readdata_q   <= readdata_d;
      end
   end

`ifdef NBODY_IRQ_EN
   logic irq_q, irq_d;

   always_comb begin
      irq_d = irq_q;
      if (rd_ctrl || go)
         irq_d = 1'b0;
      if (done_d && !done_q)
         irq_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) irq_q <= 1'b0;
      else        irq_q <= irq_d;
   end

   assign irq = irq_q;
`else
   logic unused_rd_ctrl;
   assign unused_rd_ctrl = rd_ctrl;
`endif

endmodule

// File: tb/tb_nbody_step_sequencer.sv
// Scoreboard bench for nbody_step_sequencer: expected pairs/positions queued at GO, popped on strobes.
`timescale 1ns/1ps
module tb_nbody_step_sequencer;
   localparam int BODIES  = 512;
   localparam int STEP_W  = 16;
   localparam int ACC_LAT = 58;
   localparam int POS_LAT = 20;
   localparam int REG_AW  = 3;
   localparam int IW      = 9;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pair_valid, first_j, last_j, pos_valid, busy;
   logic [IW-1:0] pair_i, pair_j, pos_idx;
`ifdef NBODY_IRQ_EN
   logic          irq;
`endif

   nbody_step_sequencer_if #(.REG_AW(REG_AW)) bus ();

   nbody_step_sequencer #(
      .BODIES(BODIES), .STEP_W(STEP_W), .ACC_LAT(ACC_LAT), .POS_LAT(POS_LAT), .REG_AW(REG_AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .pair_valid(pair_valid), .pair_i(pair_i), .pair_j(pair_j),
      .first_j(first_j), .last_j(last_j),
      .pos_valid(pos_valid), .pos_idx(pos_idx), .busy(busy)
`ifdef NBODY_IRQ_EN
      ,.irq(irq)
`endif
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_pairs[$];
   int          exp_pos[$];
   int          pairs_seen = 0, pos_seen = 0;
   int          cyc = 0, last_pair_cyc = 0, last_pos_cyc = 0;
   logic        prev_pv = 1'b0, prev_posv = 1'b0, prev_busy = 1'b0, pos_in_run = 1'b0;
   logic        timing_en = 1'b1;

   task automatic check(input string tag, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [31:0] e;
      int          p;
      cyc++;
      if (busy && !prev_busy) pos_in_run = 1'b0;
      if (pair_valid) begin
         pairs_seen++;
         if (!prev_pv && pos_in_run && timing_en)
            check("pos_to_acc_gap", cyc - last_pos_cyc - 1, POS_LAT);
         if (exp_pairs.size() == 0) check("pair_unexpected", 1, 0);
         else begin
            e = exp_pairs.pop_front();
            check("pair", {pair_i, pair_j, first_j, last_j}, e);
         end
         last_pair_cyc = cyc;
      end else begin
         check("strobe_idle", {first_j, last_j}, 0);
      end
      if (pos_valid) begin
         pos_seen++;
         if (!prev_posv && timing_en)
            check("acc_to_pos_gap", cyc - last_pair_cyc - 1, ACC_LAT);
         if (exp_pos.size() == 0) check("pos_unexpected", 1, 0);
         else begin
            p = exp_pos.pop_front();
            check("pos_idx", pos_idx, p);
         end
         last_pos_cyc = cyc;
         pos_in_run = 1'b1;
      end
      if (!busy && prev_busy && timing_en)
         check("pos_to_idle_gap", cyc - last_pos_cyc, POS_LAT + 2);
      prev_pv   = pair_valid;
      prev_posv = pos_valid;
      prev_busy = busy;
   end

   task automatic bus_write(input int addr, input logic [31:0] data);
      @(posedge clk); #1;
      bus.chipselect = 1'b1; bus.write = 1'b1;
      bus.address = REG_AW'(addr); bus.writedata = data;
      @(posedge clk); #1;
      bus.chipselect = 1'b0; bus.write = 1'b0;
   endtask

   task automatic read_check(input string tag, input int addr, input logic [31:0] exp);
      @(posedge clk); #1;
      bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = REG_AW'(addr);
      @(posedge clk); #1;
      bus.chipselect = 1'b0; bus.read = 1'b0;
      check(tag, bus.readdata, exp);
   endtask

   task automatic push_run(input int n, input int steps);
      for (int s = 0; s < steps; s++) begin
         for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
               if (j != i) begin
                  logic f, l;
                  f = (j == ((i == 0) ? 1 : 0));
                  l = (j == ((i == n - 1) ? n - 2 : n - 1));
                  exp_pairs.push_back({11'b0, IW'(i), IW'(j), f, l});
               end
         for (int p = 0; p < n; p++) exp_pos.push_back(p);
      end
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (busy && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      check("run_timeout", busy, 0);
   endtask

   task automatic run(input int n, input int steps, input int exp_steps);
      int p0, q0;
      p0 = pairs_seen; q0 = pos_seen;
      bus_write(1, 32'(n));
      bus_write(2, 32'(steps));
      push_run(n, exp_steps);
      bus_write(0, 32'h1);
      check("busy_after_go", busy, 1);
      wait_idle(20000);
      check("pair_count", pairs_seen - p0, exp_steps * n * (n - 1));
      check("pos_count", pos_seen - q0, exp_steps * n);
      check("pair_queue_left", exp_pairs.size(), 0);
      check("pos_queue_left", exp_pos.size(), 0);
`ifdef NBODY_IRQ_EN
      check("irq_on_done", irq, 1);
`endif
      read_check("ctrl_done", 0, 32'h2);
`ifdef NBODY_IRQ_EN
      check("irq_cleared_by_read", irq, 0);
`endif
      read_check("step_count", 3, 32'(exp_steps));
   endtask

   initial begin
      int p0;
      bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
      bus.address = '0; bus.writedata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {pair_valid, first_j, last_j, pos_valid, busy, pair_i, pair_j, pos_idx}, 0);
      rst_n = 1'b1;
      read_check("reset_ctrl", 0, 32'h0);
      read_check("reset_nbodies", 1, 32'h0);
      read_check("reset_steps", 2, 32'h0);
      read_check("reset_step_count", 3, 32'h0);
      read_check("unmapped_read", 5, 32'h0);

      run(3, 1, 1);
      run(4, 3, 3);
      run(2, 0, 1);

      bus_write(1, 32'd1000);
      read_check("nbodies_saturate", 1, 32'd512);
      bus_write(2, 32'h0001_2345);
      read_check("steps_truncate", 2, 32'h2345);

      p0 = pairs_seen;
      bus_write(1, 32'd1);
      bus_write(0, 32'h1);
      check("err_go_busy", busy, 0);
      repeat (5) @(posedge clk);
      #1;
      check("err_go_no_pairs", pairs_seen - p0, 0);
      read_check("err_go_ctrl", 0, 32'h6);

`ifdef NBODY_IRQ_EN
      bus_write(1, 32'd2);
      bus_write(2, 32'd1);
      push_run(2, 1);
      bus_write(0, 32'h1);
      wait_idle(2000);
      check("irq_set", irq, 1);
      push_run(2, 1);
      bus_write(0, 32'h1);
      check("irq_cleared_by_go", irq, 0);
      wait_idle(2000);
      read_check("irq_run_ctrl", 0, 32'h2);
`endif

      // abort in ACCEL of step 2, with an ignored GO and N_BODIES write during step 1
      bus_write(1, 32'd3);
      bus_write(2, 32'd5);
      push_run(3, 5);
      p0 = pairs_seen;
      bus_write(0, 32'h1);
      bus_write(0, 32'h1);
      bus_write(1, 32'd7);
      begin
         int k = 0;
         while ((pairs_seen - p0) < 7 && k < 2000) begin
            @(posedge clk); #1;
            k++;
         end
         check("abort_wait_timeout", ((pairs_seen - p0) >= 7) ? 1 : 0, 1);
      end
      timing_en = 1'b0;
      bus_write(0, 32'h2);
      check("abort_busy", busy, 0);
      check("abort_strobes", {pair_valid, pos_valid}, 0);
      exp_pairs.delete();
      exp_pos.delete();
      read_check("abort_ctrl", 0, 32'h0);
      read_check("abort_step_count", 3, 32'd1);
      read_check("busy_nbodies_ignored", 1, 32'd3);
`ifdef NBODY_IRQ_EN
      check("abort_no_irq", irq, 0);
`endif
      timing_en = 1'b1;

      // GO and ABORT together: abort wins
      bus_write(0, 32'h3);
      check("go_abort_busy", busy, 0);

      // reset in the middle of a run
      bus_write(1, 32'd4);
      bus_write(2, 32'd2);
      push_run(4, 2);
      bus_write(0, 32'h1);
      repeat (10) @(posedge clk);
      timing_en = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("midrun_reset_outputs", {pair_valid, first_j, last_j, pos_valid, busy, pair_i, pair_j, pos_idx}, 0);
      check("midrun_reset_readdata", bus.readdata, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_pairs.delete();
      exp_pos.delete();
      read_check("midrun_reset_ctrl", 0, 32'h0);
      read_check("midrun_reset_step_count", 3, 32'h0);
      read_check("midrun_reset_nbodies", 1, 32'h0);
      timing_en = 1'b1;

      run(3, 2, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
